// File: rtl/chimera_eoc_pkg.sv
// Shared types and helpers for the Chimera end-of-computation collector.
// A code word carries the EOC flag in its LSB and the exit value above it.
package chimera_eoc_pkg;

  typedef enum logic [1:0] {
    EOC_IDLE   = 2'd0,
    EOC_ARMED  = 2'd1,
    EOC_RESULT = 2'd2
  } eoc_state_e;

  localparam int EocFlagBit = 0;

  // Widest code word the helper accepts; callers zero-extend and truncate back.
  localparam int MaxExitWidth = 64;

  function automatic logic [MaxExitWidth-2:0] eoc_value(input logic [MaxExitWidth-1:0] code);
    return code[MaxExitWidth-1:1];
  endfunction

endpackage

// File: rtl/chimera_eoc_collector_if.sv
// Bundle of the collector's control, per-channel write and result signals.
// Handshakes: a transfer happens on a clock edge where valid && ready; a source holds
// its word stable until accepted, and the collector holds its result until eoc_ready_i.
interface chimera_eoc_collector_if #(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned ExitWidth    = 32,
  parameter int unsigned TimeoutWidth = 32
);
  logic                                  arm_i;
  logic                                  mode_i;
  logic [TimeoutWidth-1:0]               timeout_i;
  logic [NumChannels-1:0]                ch_valid_i;
  logic [NumChannels-1:0][ExitWidth-1:0] ch_code_i;
  logic [NumChannels-1:0]                ch_ready_o;
  logic                                  eoc_valid_o;
  logic                                  eoc_ready_i;
  logic [ExitWidth-2:0]                  exit_code_o;
  logic                                  timeout_o;
  logic [NumChannels-1:0]                done_mask_o;
  logic                                  busy_o;

  modport master (
    output arm_i, mode_i, timeout_i, ch_valid_i, ch_code_i, eoc_ready_i,
    input  ch_ready_o, eoc_valid_o, exit_code_o, timeout_o, done_mask_o, busy_o
  );

  modport slave (
    input  arm_i, mode_i, timeout_i, ch_valid_i, ch_code_i, eoc_ready_i,
    output ch_ready_o, eoc_valid_o, exit_code_o, timeout_o, done_mask_o, busy_o
  );
endinterface

// File: rtl/chimera_eoc_timer.sv
// Loadable run timer: clear latches the limit, enable counts, expired flags the
// last allowed cycle. A zero limit never expires.
module chimera_eoc_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);
  logic [Width-1:0] count;
  logic [Width-1:0] limit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      limit_q <= '0;
    end else if (clear) begin
      count   <= '0;
      limit_q <= limit;
    end else if (enable) begin
      count <= count + Width'(1);
    end
  end

  // count == limit-1 in the cycle that is limit cycles after the arm edge
  assign expired = enable && (limit_q != '0) && (count == limit_q - Width'(1));

endmodule

// File: rtl/chimera_eoc_collector.sv
// Multi-channel EOC collector: waits for all/any channel to flag EOC (or a timeout)
// and presents one aggregated exit code through a valid/ready result port.
module chimera_eoc_collector
  import chimera_eoc_pkg::*;
#(
  parameter int unsigned NumChannels  = 4,
  parameter int unsigned ExitWidth    = 32,
  parameter int unsigned TimeoutWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  chimera_eoc_collector_if.slave        bus,
  output eoc_state_e                    state_o
);
  eoc_state_e             state;
  logic                   mode_q;
  logic [NumChannels-1:0] done_mask;
  logic [ExitWidth-2:0]   cap_q;
  logic                   have_cap_q;
  logic                   valid_q;
  logic [ExitWidth-2:0]   exit_q;
  logic                   timeout_q;
  logic                   busy_q;

  logic [NumChannels-1:0] hit;
  logic [NumChannels-1:0] nz;
  logic [ExitWidth-2:0]   val [NumChannels];
  logic                   pick_valid;
  logic [ExitWidth-2:0]   pick_value;
  logic [NumChannels-1:0] done_next;
  logic                   complete;
  logic [ExitWidth-2:0]   cap_next;
  logic                   arm_fire;
  logic                   expired;

  assign arm_fire       = (state == EOC_IDLE) && bus.arm_i;
  assign bus.ch_ready_o = (state == EOC_ARMED) ? ~done_mask : '0;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    assign val[i] = (ExitWidth-1)'(eoc_value(MaxExitWidth'(bus.ch_code_i[i])));
    assign hit[i] = bus.ch_valid_i[i] && bus.ch_ready_o[i] && bus.ch_code_i[i][EocFlagBit];
    assign nz[i]  = hit[i] && (val[i] != '0);
  end

  // Lowest channel index wins among same-cycle nonzero values
  always_comb begin
    pick_valid = 1'b0;
    pick_value = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (nz[i]) begin
        pick_valid = 1'b1;
        pick_value = val[i];
      end
    end
  end

  assign done_next = done_mask | hit;
  assign complete  = mode_q ? (|done_next) : (&done_next);
  assign cap_next  = have_cap_q ? cap_q : pick_value;

  chimera_eoc_timer #(.Width(TimeoutWidth)) u_timer (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .clear   (arm_fire),
    .enable  (state == EOC_ARMED),
    .limit   (bus.timeout_i),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= EOC_IDLE;
      mode_q     <= 1'b0;
      done_mask  <= '0;
      cap_q      <= '0;
      have_cap_q <= 1'b0;
      valid_q    <= 1'b0;
      exit_q     <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        EOC_IDLE: begin
          if (bus.arm_i) begin
            state      <= EOC_ARMED;
            mode_q     <= bus.mode_i;
            done_mask  <= '0;
            cap_q      <= '0;
            have_cap_q <= 1'b0;
            exit_q     <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        EOC_ARMED: begin
          done_mask  <= done_next;
          cap_q      <= cap_next;
          have_cap_q <= have_cap_q | pick_valid;
          // Completion takes priority over a same-cycle expiry
          if (complete) begin
            state     <= EOC_RESULT;
            valid_q   <= 1'b1;
            exit_q    <= cap_next;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (expired) begin
            state     <= EOC_RESULT;
            valid_q   <= 1'b1;
            exit_q    <= '1;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        EOC_RESULT: begin
          if (bus.eoc_ready_i) begin
            state   <= EOC_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= EOC_IDLE;
      endcase
    end
  end

  assign bus.eoc_valid_o = valid_q;
  assign bus.exit_code_o = exit_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.done_mask_o = done_mask;
  assign bus.busy_o      = busy_q;
  assign state_o         = state;

endmodule

// File: doc/chimera_eoc_collector.md
# chimera_eoc_collector

Synthesizable multi-channel end-of-computation (EOC) collector for the Chimera SoC. It gathers exit-code writes from `NumChannels` sources (host core plus clusters), and waits for either all of them or any one of them, with an optional cycle timeout. It then presents one aggregated exit code through a valid/ready handshake. The block sits between the per-cluster scratch/exit registers and the SoC-level EOC reporting path (JTAG/UART/serial-link pollers). It generalises the single-source EOC wait to N channels, two completion modes and timeout detection.

## Interface
- `NumChannels`, default 4: number of EOC sources, ≥1.
- `ExitWidth`, default 32: width of a channel code word. Bit 0 is the EOC flag; bits `[ExitWidth-1:1]` carry the exit value.
- `TimeoutWidth`, default 32: width of the timeout counter and of `timeout_i`.
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `arm_i` in 1: start a collection run. Sampled only in IDLE.
- `mode_i` in 1: completion mode. 0 = all channels, 1 = any channel. Sampled at arm.
- `timeout_i` in TimeoutWidth: timeout in cycles. 0 disables the timeout. Sampled at arm.
- `ch_valid_i` in NumChannels: per-channel code write valid.
- `ch_code_i` in NumChannels×ExitWidth: per-channel code word.
- `ch_ready_o` out NumChannels: per-channel accept.
- `eoc_valid_o` out 1: aggregated result valid.
- `eoc_ready_i` in 1: result consumed.
- `exit_code_o` out ExitWidth-1: aggregated exit value.
- `timeout_o` out 1: result was caused by timeout. Valid with `eoc_valid_o`.
- `done_mask_o` out NumChannels: channels that have signalled EOC in the current run.
- `busy_o` out 1: high in ARMED.

## Operation
- FSM states: IDLE, ARMED, RESULT.
  - IDLE→ARMED on `arm_i`. On that edge: clear `done_mask`, clear the captured code, clear the counter, latch `mode_i`/`timeout_i`.
  - ARMED→RESULT when the completion condition holds or the timeout expires.
  - RESULT→IDLE on `eoc_valid_o && eoc_ready_i`.
  - `arm_i` is ignored in ARMED and RESULT.
- `ch_ready_o[i]` = ARMED && !done_mask[i]. The channel accepts when valid && ready.
- Accepted word with bit 0 = 1: sets `done_mask[i]`. Accepted word with bit 0 = 0: consumed and discarded, no state change.
- Exit value capture: the first nonzero value `code[ExitWidth-1:1]` accepted with bit 0 = 1 is latched and later ones are ignored. For same-cycle arrivals, the lowest channel index wins. If every value is zero, the result is 0.
- Completion condition:
  - mode 0: `done_mask` (including this cycle's accepts) is all ones.
  - mode 1: any bit of `done_mask` is set.
- Timeout: the counter increments every ARMED cycle. It expires when `timeout_i`≠0 and the counter equals `timeout_i`−1 without completion. On expiry: `timeout_o`=1 and `exit_code_o` = all ones. The captured value is discarded; `done_mask_o` keeps partial progress.
- Simultaneous completion and expiry in the same cycle: completion wins and `timeout_o`=0.
- Channel writes in IDLE/RESULT: ready is low, so they are not accepted and the source stalls.

## Timing
- Reset values: `ch_ready_o`=0, `eoc_valid_o`=0, `exit_code_o`=0, `timeout_o`=0, `done_mask_o`=0, `busy_o`=0; state IDLE, counter 0.
- Reset asserted mid-run aborts immediately to IDLE with no result produced.
- Arm sampled at cycle 0 → `busy_o`/`ch_ready_o` high from cycle 1.
- EOC accepted at cycle t → `done_mask_o` updated at t+1. If that accept completes the run, `eoc_valid_o` is high at t+1 and `busy_o` is low at t+1.
- With no completion, `eoc_valid_o` rises at cycle `timeout_i`+1 after the arm cycle.
- `eoc_valid_o`, `exit_code_o`, `timeout_o` and `done_mask_o` stay stable while valid and not ready. `eoc_valid_o` drops the cycle after the handshake.
- A new `arm_i` is accepted the cycle after the handshake at the earliest.

## Structure
- Package `chimera_eoc_pkg` holds:
  - the state enum `eoc_state_e`;
  - `EocFlagBit` = 0;
  - the function `eoc_value(code)`, which returns `code[ExitWidth-1:1]`.
- Sub-module `chimera_eoc_timer` holds the loadable timeout counter with clear, enable and expiry compare.
- The per-channel done/capture logic is a generate loop in the top.

## Test plan
- Mode 0, N=4, timeout 0. Channels 2, 0, 3, 1 write `0x1` on separate cycles → `eoc_valid_o` 1 cycle after channel 1, `exit_code_o`=0, `timeout_o`=0, `done_mask_o`=`4'hF`.
- Mode 1. Channel 3 writes `0x7` and channel 1 writes `0xB` in the same cycle → result `exit_code_o`=5 (channel 1 value wins), `done_mask_o`=`4'b1010`.
- Mode 0, timeout 20. Only channels 0 and 1 complete → `eoc_valid_o` at cycle 21, `timeout_o`=1, `exit_code_o`=all ones, `done_mask_o`=`4'b0011`.
- Mode 0, timeout 10. The last channel completes exactly at the expiry cycle → `timeout_o`=0 and the normal exit code is reported.
- Hold `eoc_ready_i` low 5 cycles with the result pending:
  - outputs stay stable;
  - `arm_i` is ignored;
  - channel writes are stalled with ready low;
  - after the handshake, a re-arm starts a clean run with `done_mask_o`=0.
- Status word `0x4` (bit 0 = 0), then reset asserted mid-run → the status word leaves no change; after reset all outputs are 0 and the FSM is in IDLE.
